audio_out_buffer: RTL

Memory-mapped output stage downstream of the 24-bit ASIP's MEM stage. It snoops the processor's data-memory write bus and captures stores addressed to `OUT_ADDR` into a small FIFO. It releases one 24-bit audio sample per sample-rate tick to the audio DAC/serializer. It also reports buffer level, overflow and underflow so software can pace its processing loop.

---
 rtl/audio_pkg.sv | 10 +
 rtl/audio_out_buffer_fifo.sv | 61 ++++++
 rtl/audio_out_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Constants shared by the ASIP, its test programs and the audio output stage.
package audio_pkg;
  localparam int          AUDIO_DATA_W   = 24;
  localparam logic [23:0] AUDIO_OUT_ADDR = 24'hFFFFF0;
  localparam int          AUDIO_CLK_DIV  = 1134;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/audio_out_buffer_fifo.sv
// Level-counted synchronous FIFO. Allows a simultaneous pop to free the slot
// for a push when full; never falls through when empty.
module sync_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       push_ok_o,
  output logic                       pop_ok_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign pop_ok_o  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok_o = push_i && (!full_o || pop_ok_o);
  assign rdata_o   = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = push_ok_o ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_o  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok_o, pop_ok_o})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/audio_out_buffer.sv
// Snoops ASIP stores to OUT_ADDR into a FIFO and releases one sample per
// sample-rate tick, with level, overflow and underflow status for software.
module audio_out_buffer
  import audio_pkg::*;
#(
  parameter int                       DATA_W   = AUDIO_DATA_W,
  parameter int                       DEPTH    = 16,
  parameter logic [AUDIO_DATA_W-1:0]  OUT_ADDR = AUDIO_OUT_ADDR,
  parameter int                       CLK_DIV  = AUDIO_CLK_DIV
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W-1:0]        sample_out,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     full,
  output logic                     overflow,
  output logic [15:0]              underflow_cnt
);
  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              strobe_q, strobe_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       underflow_q, underflow_d;

  logic              hit, tick;
  logic [DATA_W-1:0] head;
  logic              empty, push_ok, pop_ok;

  assign hit  = mem_write && (mem_addr == DATA_W'(OUT_ADDR));
  assign tick = enable && (div_cnt_q == DIV_W'(CLK_DIV - 1));

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (hit),
    .pop_i     (tick),
    .wdata_i   (mem_wdata),
    .rdata_o   (head),
    .level_o   (fifo_level),
    .full_o    (full),
    .empty_o   (empty),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok)
  );

  always_comb begin
    div_cnt_d   = '0;
    if (enable && !tick) div_cnt_d = div_cnt_q + DIV_W'(1);
    sample_d    = pop_ok ? head : sample_q;
    strobe_d    = pop_ok;
    // Only a store that the FIFO actually refused counts as overflow.
    overflow_d  = overflow_q || (hit && !push_ok);
    underflow_d = (tick && empty) ? sat_inc16(underflow_q) : underflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      sample_q    <= '0;
      strobe_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sample_q    <= sample_d;
      strobe_q    <= strobe_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign overflow      = overflow_q;
  assign underflow_cnt = underflow_q;
endmodule
